// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction memory model.
//   word_t         - 32-bit machine word
//   imem_state_t   - access FSM states (IDLE, WAIT, DONE)
//   HALT_WORD      - word returned for unlisted or illegal locations
//   IMEM_INIT      - power-on program image, word 0 upward
//   imem_init_word - reset value of word idx (image, else HALT_WORD)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } imem_state_t;

    localparam word_t HALT_WORD = 32'hFFFF_FFFF;

    localparam int IMEM_INIT_N = 8;
    localparam word_t IMEM_INIT [IMEM_INIT_N] = '{
        32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193,
        32'h0041_0213, 32'h0051_82B3, 32'h4062_8333, 32'h0000_006F
    };

    function automatic word_t imem_init_word(input int idx);
        word_t w;
        w = HALT_WORD;
        for (int k = 0; k < IMEM_INIT_N; k++) begin
            if (idx == k) w = IMEM_INIT[k];
        end
        return w;
    endfunction

endpackage

// File: rtl/latency_imem_wait_counter.sv
// Loadable down-counter used to time the access latency.
//   clk_i, rst_ni - clock, async active-low reset (counter clears to 0)
//   load_i, val_i - load val_i (has priority over decrement)
//   dec_i         - decrement by one, saturating at zero
//   cnt_o, zero_o - current count and count==0 flag
module wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latency_imem.sv
// Fixed-latency instruction memory with a program-load write port.
// A request held on iREN is answered LAT+1 cycles after acceptance with a
// one-cycle ihit; iload/ierr are valid in that cycle and iload holds its
// value afterwards. Misaligned or out-of-range addresses return HALT_WORD
// with ierr=1.
//   CLK, nRST                        - clock, async active-low reset
//   iREN, iaddr                      - read request / byte address
//   ihit, iload, ierr                - response
//   pload_en, pload_addr, pload_data - word write port, usable any time
// Build option: define LATENCY_IMEM_BUF_EN to add a one-entry buffer of the
// last good completed access that answers a repeat request in the same cycle.
module latency_imem
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     iREN,
    input  logic [31:0]              iaddr,
    output logic                     ihit,
    output logic [31:0]              iload,
    output logic                     ierr,
    input  logic                     pload_en,
    input  logic [$clog2(DEPTH)-1:0] pload_addr,
    input  logic [31:0]              pload_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    imem_state_t   state_q;
    word_t         addr_q;
    word_t         iload_q, iload_d;
    word_t         mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          bad;
    word_t         rd_word;
    logic [CW-1:0] cnt;
    logic          cnt_zero, cnt_last;
    logic          cnt_load, cnt_dec;
    logic          addr_chg;

    // Decode of the latched address; the array is read combinationally in
    // DONE so any write landing before DONE is seen, while a write in the
    // DONE cycle itself only takes effect after the hit.
    assign idx     = addr_q[AW+1:2];
    assign bad     = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);
    assign rd_word = bad ? HALT_WORD : mem_q[idx];

    logic  buf_hit;
    word_t hit_word;

`ifdef LATENCY_IMEM_BUF_EN
    logic  buf_vld_q;
    word_t buf_addr_q, buf_data_q;
    logic  buf_set, buf_kill;

    assign buf_hit  = (state_q == IDLE) && iREN && buf_vld_q && (iaddr == buf_addr_q);
    assign hit_word = buf_hit ? buf_data_q : rd_word;
    assign buf_set  = (state_q == DONE) && !bad;
    // Compare against the entry being written this cycle if there is one,
    // so a load into the word completing right now also invalidates it.
    assign buf_kill = pload_en && (pload_addr == (buf_set ? idx : buf_addr_q[AW+1:2]));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            if (buf_set) begin
                buf_addr_q <= addr_q;
                buf_data_q <= rd_word;
            end
            if (buf_kill)     buf_vld_q <= 1'b0;
            else if (buf_set) buf_vld_q <= 1'b1;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign hit_word = rd_word;
`endif

    // Wait counter: loaded on acceptance and on an address change in WAIT.
    assign addr_chg = (iaddr != addr_q);
    assign cnt_load = ((state_q == IDLE) && iREN && !buf_hit) ||
                      ((state_q == WAIT) && iREN && addr_chg);
    assign cnt_dec  = (state_q == WAIT);
    assign cnt_last = (cnt == CW'(1)) || cnt_zero;

    wait_counter #(.WIDTH(CW)) u_cnt (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .val_i  (CW'(LAT)),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iREN && !buf_hit) begin
                        addr_q  <= iaddr;
                        state_q <= (LAT == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!iREN) begin
                        state_q <= IDLE;
                    end else if (addr_chg) begin
                        addr_q <= iaddr;
                    end else if (cnt_last) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response outputs; iload_q keeps the last delivered word between hits.
    assign ihit    = (state_q == DONE) || buf_hit;
    assign ierr    = (state_q == DONE) && bad;
    assign iload   = ihit ? hit_word : iload_q;
    assign iload_d = ihit ? hit_word : iload_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) iload_q <= '0;
        else       iload_q <= iload_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= imem_init_word(i);
        end else if (pload_en) begin
            mem_q[pload_addr] <= pload_data;
        end
    end

endmodule

// File: tb/tb_latency_imem.sv
`timescale 1ns/1ps
module tb_latency_imem;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iren2 = 1'b0, iren3 = 1'b0, pload_en = 1'b0;
    logic [31:0] iaddr = '0, pload_data = '0;
    logic [3:0]  pload_addr = '0;
    logic        ihit2, ierr2, ihit3, ierr3;
    logic [31:0] iload2, iload3;

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t q2[$];
    exp_t q3[$];

    latency_imem #(.LAT(2), .DEPTH(16)) u2 (
        .CLK(CLK), .nRST(nRST), .iREN(iren2), .iaddr(iaddr),
        .ihit(ihit2), .iload(iload2), .ierr(ierr2),
        .pload_en(pload_en), .pload_addr(pload_addr), .pload_data(pload_data)
    );

    latency_imem #(.LAT(3), .DEPTH(16)) u3 (
        .CLK(CLK), .nRST(nRST), .iREN(iren3), .iaddr(iaddr),
        .ihit(ihit3), .iload(iload3), .ierr(ierr3),
        .pload_en(pload_en), .pload_addr(pload_addr), .pload_data(pload_data)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every hit must match the oldest pending expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST === 1'b1) begin
            nvec++;
            if (ihit2 === 1'b1) begin
                if (q2.size() == 0) begin
                    nfail++;
                    $display("FAIL u2_unexpected_hit: cycle %0d iload %h", cyc, iload2);
                end else begin
                    e = q2.pop_front();
                    if (cyc !== e.cyc || iload2 !== e.data || ierr2 !== e.err) begin
                        nfail++;
                        $display("FAIL u2_hit: got cycle %0d iload %h ierr %b, want cycle %0d iload %h ierr %b",
                                 cyc, iload2, ierr2, e.cyc, e.data, e.err);
                    end
                end
            end else if (ierr2 !== 1'b0) begin
                nfail++;
                $display("FAIL u2_ierr_without_hit: cycle %0d ierr %b, want 0", cyc, ierr2);
            end
            nvec++;
            if (ihit3 === 1'b1) begin
                if (q3.size() == 0) begin
                    nfail++;
                    $display("FAIL u3_unexpected_hit: cycle %0d iload %h", cyc, iload3);
                end else begin
                    e = q3.pop_front();
                    if (cyc !== e.cyc || iload3 !== e.data || ierr3 !== e.err) begin
                        nfail++;
                        $display("FAIL u3_hit: got cycle %0d iload %h ierr %b, want cycle %0d iload %h ierr %b",
                                 cyc, iload3, ierr3, e.cyc, e.data, e.err);
                    end
                end
            end else if (ierr3 !== 1'b0) begin
                nfail++;
                $display("FAIL u3_ierr_without_hit: cycle %0d ierr %b, want 0", cyc, ierr3);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int u, input int c, input logic [31:0] d, input logic e);
        exp_t x;
        x.cyc = c; x.data = d; x.err = e;
        if (u == 2) q2.push_back(x);
        else        q3.push_back(x);
    endtask

    task automatic do_reset();
        nRST = 1'b0; iren2 = 1'b0; iren3 = 1'b0; pload_en = 1'b0;
        iaddr = '0; pload_addr = '0; pload_data = '0;
        q2.delete(); q3.delete();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic req(input int u, input logic [31:0] a, input logic [31:0] d, input logic e);
        @(posedge CLK); #1;
        iaddr = a;
        if (u == 2) begin iren2 = 1'b1; push(2, cyc + 3, d, e); end
        else        begin iren3 = 1'b1; push(3, cyc + 4, d, e); end
    endtask

    task automatic drain(input int u, input int budget);
        int n = 0;
        while (((u == 2) ? q2.size() : q3.size()) != 0 && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        nvec++;
        if (((u == 2) ? q2.size() : q3.size()) != 0) begin
            nfail++;
            $display("FAIL drain_u%0d: hit still pending after %0d cycles", u, budget);
            if (u == 2) q2.delete(); else q3.delete();
        end
    endtask

    task automatic release_req();
        @(posedge CLK); #1;
        iren2 = 1'b0; iren3 = 1'b0; pload_en = 1'b0;
    endtask

    task automatic access(input int u, input logic [31:0] a, input logic [31:0] d, input logic e);
        req(u, a, d, e);
        drain(u, 12);
        release_req();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nRST = 1'b0;
        @(negedge CLK); #1;
        nvec += 6;
        if (ihit2 !== 1'b0)  begin nfail++; $display("FAIL reset_ihit2: got %b want 0", ihit2); end
        if (ierr2 !== 1'b0)  begin nfail++; $display("FAIL reset_ierr2: got %b want 0", ierr2); end
        if (iload2 !== 32'h0) begin nfail++; $display("FAIL reset_iload2: got %h want 0", iload2); end
        if (ihit3 !== 1'b0)  begin nfail++; $display("FAIL reset_ihit3: got %b want 0", ihit3); end
        if (ierr3 !== 1'b0)  begin nfail++; $display("FAIL reset_ierr3: got %b want 0", ierr3); end
        if (iload3 !== 32'h0) begin nfail++; $display("FAIL reset_iload3: got %h want 0", iload3); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        access(2, 32'h04, IMEM_INIT[1], 1'b0);
        repeat (2) begin
            @(negedge CLK); #1;
            nvec++;
            if (iload2 !== IMEM_INIT[1] || ihit2 !== 1'b0) begin
                nfail++;
                $display("FAIL iload_hold: got iload %h ihit %b, want %h 0", iload2, ihit2, IMEM_INIT[1]);
            end
        end
        access(2, 32'h00, IMEM_INIT[0], 1'b0);
        access(2, 32'h1C, IMEM_INIT[7], 1'b0);
        access(2, 32'h3C, HALT_WORD, 1'b0);   // last in-range word, not in image
    endtask

    task automatic test_lat3_restart();
        do_reset();
        @(posedge CLK); #1;
        iaddr = 32'h08; iren3 = 1'b1;
        push(3, cyc + 6, IMEM_INIT[3], 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        iaddr = 32'h0C;
        drain(3, 12);
        release_req();
        access(3, 32'h10, IMEM_INIT[4], 1'b0);
    endtask

    task automatic test_err();
        access(2, 32'h40, HALT_WORD, 1'b1);
        access(2, 32'h06, HALT_WORD, 1'b1);
        access(2, 32'h8000_0000, HALT_WORD, 1'b1);
        access(2, 32'h01, HALT_WORD, 1'b1);
    endtask

    task automatic test_pload();
        do_reset();
        @(posedge CLK); #1;
        iaddr = 32'h08; iren2 = 1'b1;
        push(2, cyc + 3, 32'h1234_5678, 1'b0);
        @(posedge CLK); #1;
        pload_en = 1'b1; pload_addr = 4'd2; pload_data = 32'h1234_5678;
        @(posedge CLK); #1;
        pload_en = 1'b0;
        drain(2, 12);
        release_req();
        // write in the DONE cycle must not change that hit
        @(posedge CLK); #1;
        iaddr = 32'h0C; iren2 = 1'b1;
        push(2, cyc + 3, IMEM_INIT[3], 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        pload_en = 1'b1; pload_addr = 4'd3; pload_data = 32'hDEAD_BEEF;
        drain(2, 12);
        release_req();
        access(2, 32'h0C, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] prev;
        prev = iload2;
        @(posedge CLK); #1;
        iaddr = 32'h14; iren2 = 1'b1;
        @(posedge CLK); #1;
        iren2 = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        nvec++;
        if (iload2 !== prev) begin
            nfail++;
            $display("FAIL abort_iload_hold: got %h want %h", iload2, prev);
        end
        access(2, 32'h14, IMEM_INIT[5], 1'b0);
    endtask

    task automatic test_reset_in_wait();
        @(posedge CLK); #1;
        iaddr = 32'h10; iren2 = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b0; iren2 = 1'b0;
        @(negedge CLK); #1;
        nvec += 3;
        if (ihit2 !== 1'b0)   begin nfail++; $display("FAIL rst_wait_ihit: got %b want 0", ihit2); end
        if (ierr2 !== 1'b0)   begin nfail++; $display("FAIL rst_wait_ierr: got %b want 0", ierr2); end
        if (iload2 !== 32'h0) begin nfail++; $display("FAIL rst_wait_iload: got %h want 0", iload2); end
        @(posedge CLK); #1;
        nRST = 1'b1;
        repeat (6) @(negedge CLK);
        #1;
        nvec++;
        if (iload2 !== 32'h0) begin nfail++; $display("FAIL rst_wait_iload_after: got %h want 0", iload2); end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        iaddr = 32'h00; iren2 = 1'b1;
        push(2, cyc + 3, IMEM_INIT[0], 1'b0);
        drain(2, 12);
        @(posedge CLK); #1;          // first IDLE cycle after the hit, iREN still high
        iaddr = 32'h04;
        push(2, cyc + 3, IMEM_INIT[1], 1'b0);
        drain(2, 12);
        release_req();
    endtask

`ifdef LATENCY_IMEM_BUF_EN
    task automatic test_buf();
        do_reset();
        access(2, 32'h10, IMEM_INIT[4], 1'b0);
        @(posedge CLK); #1;
        iaddr = 32'h10; iren2 = 1'b1;
        push(2, cyc, IMEM_INIT[4], 1'b0);
        drain(2, 4);
        release_req();
        @(posedge CLK); #1;
        pload_en = 1'b1; pload_addr = 4'd4; pload_data = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        pload_en = 1'b0;
        access(2, 32'h10, 32'hCAFE_F00D, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_lat3_restart();
        test_err();
        test_pload();
        test_abort();
        test_reset_in_wait();
        test_back_to_back();
`ifdef LATENCY_IMEM_BUF_EN
        test_buf();
`endif
        repeat (4) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
